// File: rtl/sha256_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha256_sched_pkg
// Purpose  : Shared state encoding and stride constants for the SHA-256
//            job scheduler and its address generator.
// Revision : 1.0 - initial release
// ============================================================================
package sha256_sched_pkg;

  // 4-bit encoding keeps the scheduler state width aligned with the core FSM
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ISSUE     = 4'd1,
    S_WAIT_BUSY = 4'd2,
    S_WAIT_DONE = 4'd3,
    S_NEXT      = 4'd4
  } sched_state_t;

  localparam int DIGEST_WORDS   = 8;
  localparam int DEF_MSG_STRIDE = 20;
  localparam int DEF_OUT_STRIDE = DIGEST_WORDS;

endpackage
`default_nettype wire

// File: rtl/sha256_job_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : sha256_job_addr_gen
// Purpose  : Message/digest address registers for the current job; loaded
//            from the batch bases and advanced by a fixed stride (mod 2^16).
// Revision : 1.0 - initial release
// ============================================================================
module sha256_job_addr_gen
  import sha256_sched_pkg::*;
#(
  parameter int MSG_STRIDE = DEF_MSG_STRIDE,
  parameter int OUT_STRIDE = DEF_OUT_STRIDE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_advance,
  input  logic [15:0] i_msg_base,
  input  logic [15:0] i_out_base,
  output logic [15:0] o_msg_addr,
  output logic [15:0] o_out_addr
);

  localparam logic [15:0] C_MSG_STEP = 16'(MSG_STRIDE);
  localparam logic [15:0] C_OUT_STEP = 16'(OUT_STRIDE);

  logic [15:0] r_msg_addr;
  logic [15:0] r_out_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_msg_addr <= '0;
      r_out_addr <= '0;
    end else if (i_load) begin
      r_msg_addr <= i_msg_base;
      r_out_addr <= i_out_base;
    end else if (i_advance) begin
      r_msg_addr <= r_msg_addr + C_MSG_STEP;
      r_out_addr <= r_out_addr + C_OUT_STEP;
    end
  end

  assign o_msg_addr = r_msg_addr;
  assign o_out_addr = r_out_addr;

endmodule
`default_nettype wire

// File: rtl/sha256_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sha256_job_scheduler
// Purpose  : Runs one SHA-256 core over a batch of messages, one job at a
//            time. Optional per-job watchdog enabled by SCHED_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_job_scheduler
  import sha256_sched_pkg::*;
#(
  parameter int MSG_STRIDE     = DEF_MSG_STRIDE,
  parameter int OUT_STRIDE     = DEF_OUT_STRIDE,
  parameter int MAX_JOBS       = 255,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] msg_base,
  input  logic [15:0] out_base,
  input  logic [7:0]  num_jobs,
  output logic        done,
  output logic        busy,
  output logic [7:0]  job_idx,
  output logic [7:0]  jobs_done,
  output logic        error,
  output logic        core_start,
  output logic [15:0] core_message_addr,
  output logic [15:0] core_output_addr,
  input  logic        core_done
);

  localparam int             CW    = $clog2(MAX_JOBS + 1);
  localparam logic [CW-1:0]  C_ONE = CW'(1);

  if (MAX_JOBS < 1 || MAX_JOBS > 255 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("sha256_job_scheduler: MAX_JOBS must be 1..255 and TIMEOUT_CYCLES >= 2");
  end

  sched_state_t  r_state;
  sched_state_t  w_next_state;
  logic [CW-1:0] r_job_idx;
  logic [CW-1:0] r_jobs_done;
  logic [CW-1:0] r_num_jobs;
  logic          r_abort_pend;
  logic          w_load;
  logic          w_advance;
  logic          w_last;
  logic          w_waiting;
  logic          w_timeout;

  assign w_last    = ((r_job_idx + C_ONE) == r_num_jobs);
  assign w_waiting = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    done         = (r_state == S_IDLE);
    busy         = (r_state != S_IDLE);
    core_start   = (r_state == S_ISSUE);
    case (r_state)
      S_IDLE: begin
        if (start && (num_jobs != 8'd0)) begin
          w_load       = 1'b1;
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: w_next_state = S_WAIT_BUSY;
      // core_done is a level that is already high before the start; it must
      // drop first, otherwise the stale high would read as completion
      S_WAIT_BUSY: begin
        if (w_timeout)       w_next_state = S_IDLE;
        else if (!core_done) w_next_state = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (w_timeout)      w_next_state = S_IDLE;
        else if (core_done) w_next_state = S_NEXT;
      end
      S_NEXT: begin
        if (w_last || r_abort_pend) begin
          w_next_state = S_IDLE;
        end else begin
          w_advance    = 1'b1;
          w_next_state = S_ISSUE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_job_idx    <= '0;
      r_jobs_done  <= '0;
      r_num_jobs   <= '0;
      r_abort_pend <= 1'b0;
    end else begin
      if (r_state == S_IDLE)  r_abort_pend <= 1'b0;
      else if (abort)         r_abort_pend <= 1'b1;
      if ((r_state == S_IDLE) && start) r_jobs_done <= '0;
      if (r_state == S_NEXT)            r_jobs_done <= r_jobs_done + C_ONE;
      if (w_load) begin
        r_num_jobs <= CW'(num_jobs);
        r_job_idx  <= '0;
      end else if (w_advance) begin
        r_job_idx  <= r_job_idx + C_ONE;
      end
    end
  end

  assign job_idx   = 8'(r_job_idx);
  assign jobs_done = 8'(r_jobs_done);

`ifdef SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_wd_cnt;
  logic          r_error;

  // fires on the TIMEOUT_CYCLES-th cycle spent waiting on the current job
  assign w_timeout = w_waiting && (r_wd_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd_cnt <= '0;
      r_error  <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) r_wd_cnt <= '0;
      else if (w_waiting)     r_wd_cnt <= r_wd_cnt + TW'(1);
      if (w_load)             r_error  <= 1'b0;
      else if (w_timeout)     r_error  <= 1'b1;
    end
  end

  assign error = r_error;
`else
  logic w_unused_wait;
  assign w_unused_wait = w_waiting;
  assign w_timeout     = 1'b0;
  assign error         = 1'b0;
`endif

  sha256_job_addr_gen #(
    .MSG_STRIDE (MSG_STRIDE),
    .OUT_STRIDE (OUT_STRIDE)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_load     (w_load),
    .i_advance  (w_advance),
    .i_msg_base (msg_base),
    .i_out_base (out_base),
    .o_msg_addr (core_message_addr),
    .o_out_addr (core_output_addr)
  );

endmodule
`default_nettype wire

// File: tb/tb_sha256_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_job_scheduler
// Purpose  : Self-checking bench: behavioural SHA core model plus batch-level
//            reference of expected start count and job addresses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_job_scheduler;

  localparam int MSG_STRIDE = 20;
  localparam int OUT_STRIDE = 8;
  localparam int TO_CYC     = 50;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] msg_base = '0;
  logic [15:0] out_base = '0;
  logic [7:0]  num_jobs = '0;
  logic        done, busy, error, core_start, core_done;
  logic [7:0]  job_idx, jobs_done;
  logic [15:0] core_message_addr, core_output_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sha256_job_scheduler #(
    .MSG_STRIDE     (MSG_STRIDE),
    .OUT_STRIDE     (OUT_STRIDE),
    .MAX_JOBS       (255),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .abort             (abort),
    .msg_base          (msg_base),
    .out_base          (out_base),
    .num_jobs          (num_jobs),
    .done              (done),
    .busy              (busy),
    .job_idx           (job_idx),
    .jobs_done         (jobs_done),
    .error             (error),
    .core_start        (core_start),
    .core_message_addr (core_message_addr),
    .core_output_addr  (core_output_addr),
    .core_done         (core_done)
  );

  // Core model: done high while idle, optionally high for core_hold cycles
  // after a start, then low for core_lat cycles (forever when hung).
  int          core_hold = 0;
  int          core_lat  = 10;
  bit          core_hang = 1'b0;
  logic        cm_active;
  int          cm_cnt;
  logic [31:0] start_log[$];

  assign core_done = !cm_active || (cm_cnt < core_hold) ||
                     (!core_hang && (cm_cnt >= core_hold + core_lat));

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cm_active <= 1'b0;
      cm_cnt    <= 0;
    end else if (core_start) begin
      cm_active <= 1'b1;
      cm_cnt    <= 0;
      start_log.push_back({core_message_addr, core_output_addr});
    end else if (cm_active) begin
      if (!core_hang && (cm_cnt >= core_hold + core_lat)) cm_active <= 1'b0;
      else                                                cm_cnt    <= cm_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] mb;
    logic [15:0] ob;
    int          n;
    int          ab;     // job index during which abort is pulsed, -1 none
    int          hold;
    int          lat;
    bit          idle_abort;
  } tcase_t;

  task automatic run_batch(input tcase_t tc);
    int          exp_n, k, rise_k;
    bit          aborted;
    logic        prev_cd;
    logic [31:0] ent;
    logic [15:0] e_msg, e_out;
    core_hold = tc.hold;
    core_lat  = tc.lat;
    start_log.delete();
    exp_n = (tc.ab >= 0 && tc.ab < tc.n) ? tc.ab + 1 : tc.n;
    if (tc.idle_abort) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    msg_base = tc.mb;
    out_base = tc.ob;
    num_jobs = 8'(tc.n);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    msg_base = 16'($urandom);
    out_base = 16'($urandom);
    num_jobs = 8'($urandom);
    chk(tc.n != 0 ? "first_start_latency" : "zero_jobs_no_start", {31'd0, core_start}, {31'd0, tc.n != 0});
    k = 0; rise_k = -100; aborted = 1'b0; prev_cd = core_done;
    while (busy && k < 5000) begin
      if (core_start) begin
        chk("start_while_core_busy", {31'd0, cm_active}, 32'd0);
        if (start_log.size() > 0) chk("done_to_start_gap", k - rise_k, 32'd2);
      end
      if (core_done && !prev_cd) rise_k = k;
      prev_cd = core_done;
      if (tc.ab >= 0 && !aborted && start_log.size() == tc.ab + 1) begin
        abort = 1'b1;
        aborted = 1'b1;
      end else begin
        abort = 1'b0;
      end
      tick();
      k++;
    end
    abort = 1'b0;
    chk("batch_finished", {31'd0, busy}, 32'd0);
    chk("start_count", start_log.size(), exp_n);
    for (int i = 0; i < exp_n && i < start_log.size(); i++) begin
      ent   = start_log[i];
      e_msg = 16'(tc.mb + i * MSG_STRIDE);
      e_out = 16'(tc.ob + i * OUT_STRIDE);
      chk("msg_addr", {16'd0, ent[31:16]}, {16'd0, e_msg});
      chk("out_addr", {16'd0, ent[15:0]},  {16'd0, e_out});
    end
    chk("jobs_done", jobs_done, exp_n);
    chk("done_idle", {31'd0, done}, 32'd1);
    chk("error_clear", {31'd0, error}, 32'd0);
    if (exp_n > 0) chk("job_idx_last", job_idx, exp_n - 1);
  endtask

  tcase_t tbl[7];
  tcase_t rc;
  int     k;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'h0000, 16'h0100, 3, -1, 0, 200, 1'b0};
    tbl[1] = '{16'h1111, 16'h2222, 0, -1, 0, 10,  1'b0};
    tbl[2] = '{16'hFFF0, 16'h0200, 2, -1, 0, 12,  1'b0};
    tbl[3] = '{16'h0040, 16'h2000, 4,  1, 0, 30,  1'b0};
    tbl[4] = '{16'h0300, 16'h0400, 3, -1, 3, 15,  1'b0};
    tbl[5] = '{16'h0500, 16'hFFFC, 2,  1, 1, 9,   1'b0};
    tbl[6] = '{16'h0600, 16'h0700, 2, -1, 0, 7,   1'b1};

    repeat (3) tick();
    chk("rst_done", {31'd0, done}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_core_start", {31'd0, core_start}, 32'd0);
    chk("rst_job_idx", job_idx, 32'd0);
    chk("rst_jobs_done", jobs_done, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_msg_addr", core_message_addr, 32'd0);
    chk("rst_out_addr", core_output_addr, 32'd0);
    reset_n = 1'b1;
    tick();

    foreach (tbl[i]) run_batch(tbl[i]);

    for (int r = 0; r < 12; r++) begin
      rc.mb         = 16'($urandom);
      rc.ob         = 16'($urandom);
      rc.n          = $urandom_range(0, 6);
      rc.ab         = ($urandom_range(0, 2) == 0) ? $urandom_range(0, rc.n) : -1;
      rc.hold       = $urandom_range(0, 3);
      rc.lat        = $urandom_range(1, 25);
      rc.idle_abort = 1'($urandom_range(0, 1));
      run_batch(rc);
    end

    // asynchronous reset while waiting on the core
    core_hold = 0; core_lat = 100;
    msg_base = 16'h0ABC; out_base = 16'h0DEF; num_jobs = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    chk("addr_stable_wait", core_message_addr, 32'h0ABC);
    reset_n = 1'b0;
    #1;
    start_log.delete();
    chk("arst_done", {31'd0, done}, 32'd1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_core_start", {31'd0, core_start}, 32'd0);
    chk("arst_job_idx", job_idx, 32'd0);
    chk("arst_jobs_done", jobs_done, 32'd0);
    chk("arst_error", {31'd0, error}, 32'd0);
    chk("arst_msg_addr", core_message_addr, 32'd0);
    chk("arst_out_addr", core_output_addr, 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    chk("no_pending_start", start_log.size(), 32'd0);
    chk("idle_after_reset", {31'd0, done}, 32'd1);

`ifdef SCHED_TIMEOUT_EN
    core_hang = 1'b1; core_hold = 0; core_lat = 5;
    msg_base = 16'h0010; out_base = 16'h0020; num_jobs = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (busy && k < 500) begin
      tick();
      k++;
    end
    chk("timeout_cycles", k, TO_CYC + 1);
    chk("timeout_error", {31'd0, error}, 32'd1);
    chk("timeout_jobs_done", jobs_done, 32'd0);
    core_hang = 1'b0;
    repeat (10) tick();
    chk("error_sticky", {31'd0, error}, 32'd1);
    rc = '{16'h0100, 16'h0200, 1, -1, 0, 5, 1'b0};
    run_batch(rc);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha256_job_scheduler.md
Name: sha256_job_scheduler

Overview:
- Sequences one simplified SHA-256 core over a batch of messages held in the shared memory.
- For job n, computes that job's message and output addresses, issues a start to the core, and waits for the core to finish before moving to job n+1.
- Sits between the host/testbench control and the SHA core's start/done/address inputs. It never touches the memory port; the core still owns mem_*.

Parameters:
- MSG_STRIDE, 20: words between consecutive message bases; equals the core's NUM_OF_WORDS.
- OUT_STRIDE, 8: words between consecutive digest outputs.
- MAX_JOBS, 255: upper bound on the num_jobs input; sets the counter width to clog2(MAX_JOBS+1).
- TIMEOUT_CYCLES, 4096: watchdog limit per job. Used only with SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin a batch; sampled only in IDLE
- abort  in  1  stop after the current job completes
- msg_base  in  16  word address of message 0
- out_base  in  16  word address of digest 0
- num_jobs  in  8  number of messages in the batch
- done  out  1  high in IDLE, including after reset
- busy  out  1  high when not in IDLE
- job_idx  out  8  index of the job in flight
- jobs_done  out  8  count of completed jobs in the current/last batch
- error  out  1  sticky watchdog flag; cleared on start (SCHED_TIMEOUT_EN only, else tied 0)
- core_start  out  1  one-cycle start pulse to the core
- core_message_addr  out  16  message base for the current job
- core_output_addr  out  16  output base for the current job
- core_done  in  1  core's level done (high while the core is in its IDLE)

Behaviour:
- Reset values: state IDLE, done=1, busy=0, core_start=0, job_idx=0, jobs_done=0, error=0, core_*_addr=0.
- Reset mid-batch returns to IDLE immediately. No pending start is remembered.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, NEXT.
- IDLE:
  - start=1 and num_jobs=0: stay in IDLE; jobs_done<=0.
  - start=1 and num_jobs>0: latch num_jobs; core_message_addr<=msg_base; core_output_addr<=out_base; job_idx<=0; jobs_done<=0; go to ISSUE.
- ISSUE: core_start=1 for exactly this cycle; go to WAIT_BUSY.
- WAIT_BUSY: wait for core_done=0, which confirms the core accepted the start; then go to WAIT_DONE.
  - The core's done is a level and is already high before the start. Waiting for it to fall prevents a false completion.
- WAIT_DONE: on core_done=1, go to NEXT.
- NEXT:
  - jobs_done<=jobs_done+1.
  - If job_idx+1==latched num_jobs, or abort has been recorded, go to IDLE.
  - Otherwise: job_idx+1; core_message_addr+=MSG_STRIDE; core_output_addr+=OUT_STRIDE; go to ISSUE.
- Address arithmetic: 16-bit, wraps modulo 2^16, no saturation.
- core_*_addr stay stable from ISSUE through WAIT_DONE.
- Latency: start to first core_start is 1 cycle. Core done to next core_start is 2 cycles.
- abort:
  - Any abort=1 while busy sets an internal abort_pend flag. The in-flight core job always completes, because the core has no abort input.
  - abort arriving in the same cycle as the final NEXT is harmless; the result is identical.
  - abort_pend clears in IDLE.
  - abort in IDLE is ignored.
- start while busy: ignored. msg_base, out_base and num_jobs may change freely after the start is accepted.

Optional Feature:
- SCHED_TIMEOUT_EN defined:
  - A counter runs in WAIT_BUSY and WAIT_DONE and resets in ISSUE.
  - Reaching TIMEOUT_CYCLES sets error=1 and forces IDLE. jobs_done excludes the hung job.
  - error holds until the next accepted start.
- SCHED_TIMEOUT_EN undefined: no counter; the block waits indefinitely; error is tied to 0.

Decomposition:
- Package sha256_sched_pkg holds:
  - the state enum sched_state_t (4-bit, matching core FSM encoding width);
  - default stride constants DEF_MSG_STRIDE=20 and DEF_OUT_STRIDE=8;
  - the SHA digest word count constant 8.
- One sub-module, sha256_job_addr_gen. It holds the two address registers with load/advance controls and the stride adders. Everything else is inline in the FSM.

Test Plan:
- msg_base=0, out_base=16'h0100, num_jobs=3, core model at 200 cycles/job:
  - 3 core_start pulses with message addrs 0, 20, 40 and output addrs 0x100, 0x108, 0x110;
  - jobs_done=3; done high after the third core_done rise.
- num_jobs=0 with start: no core_start; done stays 1; jobs_done=0.
- msg_base=16'hFFF0, num_jobs=2: second message addr is 16'h0004 (wraps).
- abort pulsed during job 1 of 4: job 1 completes; jobs_done=2; only 2 core_start pulses; back in IDLE.
- Core model holds core_done high for 3 cycles after start: scheduler stays in WAIT_BUSY; no premature completion; correct count.
- SCHED_TIMEOUT_EN with TIMEOUT_CYCLES=50 and a core that never finishes: error=1 after 50 cycles in wait; IDLE; next start clears error. Also assert reset_n low mid-WAIT_DONE: all outputs return to their reset values.
